// File: rtl/bram_reader.sv
// bram_reader: polls a frame-flag word in a BRAM, streams the flagged number of
// sample words out through a 2-entry FIFO, then clears the flag word.
module bram_reader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] FLAG_ADDR = 32'd0,
    parameter logic [31:0] BASE_ADDR = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              enable,
    output logic              we,
    output logic [31:0]       addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned       CW      = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, POLL, CHECK, STREAM, DRAIN, CLEAR
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     rem;          // sample reads still to issue
    logic [31:0]       samp_addr;    // address of the next sample read
    logic [31:0]       addr_q;       // last address driven, held while idle
    logic              rd_q;         // sample word arrives on dout this cycle
    logic              rd_last_q;    // ...and it is the final word of the frame
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] fifo_d0, fifo_d1;
    logic              fifo_l0, fifo_l1;

    logic              pop, push, room, issue, last_issue;
    logic              flag_big, flag_zero, access;
    logic [2:0]        occ;
    logic [31:0]       acc_addr;

    // The only data ever written is the flag clear, which is always zero.
    assign din = '0;

    // FIFO occupancy check: a read may be issued only if the word it returns
    // is guaranteed a FIFO slot even if the consumer stalls from now on.
    always_comb begin
        pop        = m_valid && m_ready;
        push       = rd_q;
        occ        = {1'b0, fifo_cnt} + {2'b00, rd_q};
        room       = (occ - {2'b00, pop}) < 3'd2;
        issue      = (state == STREAM) && room;
        last_issue = issue && (rem == CW'(1));
        flag_big   = dout > DEPTH_W;
        flag_zero  = dout == '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and BRAM port / status decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nx = state;
        access   = 1'b0;
        we       = 1'b0;
        acc_addr = FLAG_ADDR;
        done     = 1'b0;
        ovf      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = POLL;
            end
            POLL: begin
                access   = 1'b1;
                state_nx = CHECK;
            end
            CHECK: begin
                ovf      = flag_big;
                state_nx = flag_zero ? IDLE : STREAM;
            end
            STREAM: begin
                access   = issue;
                acc_addr = samp_addr;
                if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0 && !rd_q) state_nx = CLEAR;
            end
            CLEAR: begin
                access   = 1'b1;
                we       = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        enable = access;
        addr   = access ? acc_addr : addr_q;
        busy   = state != IDLE;
    end

    // Frame counters, held address and read-return tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            samp_addr <= BASE_ADDR;
            addr_q    <= FLAG_ADDR;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            addr_q    <= addr;
            rd_q      <= issue;
            rd_last_q <= last_issue;
            if (state == CHECK) begin
                rem       <= flag_big ? CW'(DEPTH) : dout[CW-1:0];
                samp_addr <= BASE_ADDR;
            end else if (issue) begin
                rem       <= rem - CW'(1);
                samp_addr <= samp_addr + 32'd4;
            end
        end
    end

    // Two-entry output FIFO; entry 0 is the head presented on m_data.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the FIFO storage is reset because its head drives m_data,
        // which must read zero out of reset.
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            fifo_d0  <= '0;
            fifo_d1  <= '0;
            fifo_l0  <= 1'b0;
            fifo_l1  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_d0 <= dout;
                        fifo_l0 <= rd_last_q;
                    end else begin
                        fifo_d1 <= dout;
                        fifo_l1 <= rd_last_q;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_d0  <= fifo_d1;
                    fifo_l0  <= fifo_l1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_d0 <= dout;
                        fifo_l0 <= rd_last_q;
                    end else begin
                        fifo_d0 <= fifo_d1;
                        fifo_l0 <= fifo_l1;
                        fifo_d1 <= dout;
                        fifo_l1 <= rd_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stream outputs come straight from the FIFO head.
    always_comb begin
        m_valid = fifo_cnt != 2'd0;
        m_data  = fifo_d0;
        m_last  = m_valid && fifo_l0;
    end

endmodule

// File: tb/tb_bram_reader.sv
// tb_bram_reader: directed self-checking bench for bram_reader with a
// behavioural one-cycle-latency BRAM and a negedge transfer monitor.
module tb_bram_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk, rst_n, start, m_ready;
    logic          enable, we, m_valid, m_last, busy, done, ovf;
    logic [31:0]   addr;
    logic [DW-1:0] din, dout, m_data;

    int tests = 0;
    int fails = 0;

    bram_reader #(.DATA_W(DW), .DEPTH(DEPTH), .FLAG_ADDR(32'd0), .BASE_ADDR(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .enable(enable), .we(we), .addr(addr), .din(din), .dout(dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: read data appears the cycle after the access.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (enable) begin
            if (we) mem[addr[7:2]] = din;
            else    dout <= mem[addr[7:2]];
        end
    end

    // Monitor state.
    int          cyc = 0;
    logic [31:0] rd_addrs[$];
    logic [31:0] xd[$];
    bit          xl[$];
    int          xc[$];
    int          wr_cnt, done_cnt, ovf_cnt, valid_cnt, stall_err;
    int          first_rd, first_val;
    logic [31:0] wr_addr, wr_data, prev_data;
    bit          prev_stall, prev_last;

    task automatic clear_mon();
        rd_addrs.delete(); xd.delete(); xl.delete(); xc.delete();
        wr_cnt = 0; done_cnt = 0; ovf_cnt = 0; valid_cnt = 0; stall_err = 0;
        first_rd = -1; first_val = -1; prev_stall = 1'b0;
        wr_addr = '0; wr_data = 32'hdead_beef;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (enable && !we) begin
            rd_addrs.push_back(addr);
            if (addr != 32'd0 && first_rd < 0) first_rd = cyc;
        end
        if (enable && we) begin wr_cnt++; wr_addr = addr; wr_data = din; end
        if (done) done_cnt++;
        if (ovf)  ovf_cnt++;
        if (m_valid) begin valid_cnt++; if (first_val < 0) first_val = cyc; end
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_err++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin xd.push_back(m_data); xl.push_back(m_last); xc.push_back(cyc); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic [31:0] n, input logic [31:0] base, input int words);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = n;
        for (int k = 0; k < words; k++) mem[1 + k] = base + 32'(k);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Waits for busy to fall; optionally toggles m_ready with pattern 1,0,0,1.
    task automatic wait_idle(input string tag, input bit toggle);
        logic [3:0] pat;
        bit         idle;
        pat  = 4'b1001;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            if (toggle) begin @(posedge clk); #1 m_ready = pat[i % 4]; end
            @(negedge clk); #2;
            if (!busy) idle = 1'b1;
        end
        check({tag, "_timeout"}, {31'b0, idle}, 32'd1);
        m_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, {31'b0, enable}, 32'd0);
        check({tag, "_we"},     {31'b0, we},     32'd0);
        check({tag, "_addr"},   addr,            32'd0);
        check({tag, "_din"},    din,             32'd0);
        check({tag, "_mvalid"}, {31'b0, m_valid}, 32'd0);
        check({tag, "_mlast"},  {31'b0, m_last}, 32'd0);
        check({tag, "_mdata"},  m_data,          32'd0);
        check({tag, "_busy"},   {31'b0, busy},   32'd0);
        check({tag, "_done"},   {31'b0, done},   32'd0);
        check({tag, "_ovf"},    {31'b0, ovf},    32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        clear_mon();
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Frame of 3 words, consumer always ready.
        load_frame(32'd3, 32'hA, 3);
        clear_mon();
        pulse_start();
        wait_idle("f3", 1'b0);
        check("f3_xfers", 32'(xd.size()), 32'd3);
        if (xd.size() == 3) begin
            check("f3_d0", xd[0], 32'hA);
            check("f3_d1", xd[1], 32'hB);
            check("f3_d2", xd[2], 32'hC);
            check("f3_last0", {31'b0, xl[0]}, 32'd0);
            check("f3_last2", {31'b0, xl[2]}, 32'd1);
            check("f3_gap01", 32'(xc[1] - xc[0]), 32'd1);
            check("f3_gap12", 32'(xc[2] - xc[1]), 32'd1);
        end
        check("f3_latency", 32'(first_val - first_rd), 32'd2);
        check("f3_wr_cnt", 32'(wr_cnt), 32'd1);
        check("f3_wr_addr", wr_addr, 32'd0);
        check("f3_wr_data", wr_data, 32'd0);
        check("f3_done", 32'(done_cnt), 32'd1);
        check("f3_flag_cleared", mem[0], 32'd0);

        // Zero flag: one poll, nothing streamed.
        load_frame(32'd0, 32'h55, 2);
        clear_mon();
        pulse_start();
        wait_idle("f0", 1'b0);
        check("f0_reads", 32'(rd_addrs.size()), 32'd1);
        if (rd_addrs.size() > 0) check("f0_rd_addr", rd_addrs[0], 32'd0);
        check("f0_valid", 32'(valid_cnt), 32'd0);
        check("f0_done", 32'(done_cnt), 32'd0);
        check("f0_writes", 32'(wr_cnt), 32'd0);

        // Frame of 4 words with a stalling consumer.
        load_frame(32'd4, 32'h40, 6);
        clear_mon();
        pulse_start();
        wait_idle("f4", 1'b1);
        check("f4_xfers", 32'(xd.size()), 32'd4);
        for (int k = 0; k < 4 && k < xd.size(); k++) begin
            check($sformatf("f4_d%0d", k), xd[k], 32'h40 + 32'(k));
            check($sformatf("f4_last%0d", k), {31'b0, xl[k]}, (k == 3) ? 32'd1 : 32'd0);
        end
        check("f4_stable", 32'(stall_err), 32'd0);
        check("f4_done", 32'(done_cnt), 32'd1);

        // Oversized flag is clamped to DEPTH words.
        load_frame(32'(DEPTH + 5), 32'h100, DEPTH + 5);
        clear_mon();
        pulse_start();
        wait_idle("ovf", 1'b0);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        check("ovf_xfers", 32'(xd.size()), 32'(DEPTH));
        if (xd.size() == DEPTH) begin
            check("ovf_dlast", xd[DEPTH-1], 32'h100 + 32'(DEPTH - 1));
            check("ovf_mlast", {31'b0, xl[DEPTH-1]}, 32'd1);
        end
        check("ovf_reads", 32'(rd_addrs.size()), 32'(DEPTH + 1));
        if (rd_addrs.size() > 0) check("ovf_last_addr", rd_addrs[$], 32'd4 + 32'd4 * 32'(DEPTH - 1));
        check("ovf_done", 32'(done_cnt), 32'd1);

        // Reset after 2 of 5 words, then rerun the frame.
        load_frame(32'd5, 32'h70, 5);
        clear_mon();
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk); #2;
                if (xd.size() >= 2) seen = 1'b1;
            end
            check("rst_two_seen", {31'b0, seen}, 32'd1);
        end
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check("midrst_writes", 32'(wr_cnt), 32'd0);
        check("midrst_flag_kept", mem[0], 32'd5);
        rst_n = 1'b1;
        clear_mon();
        pulse_start();
        wait_idle("rerun", 1'b0);
        check("rerun_xfers", 32'(xd.size()), 32'd5);
        for (int k = 0; k < 5 && k < xd.size(); k++)
            check($sformatf("rerun_d%0d", k), xd[k], 32'h70 + 32'(k));
        if (rd_addrs.size() > 1) check("rerun_first_addr", rd_addrs[1], 32'd4);
        check("rerun_done", 32'(done_cnt), 32'd1);

        // Second start during STREAM is ignored.
        load_frame(32'd3, 32'h90, 3);
        clear_mon();
        pulse_start();
        repeat (2) @(posedge clk);
        pulse_start();
        wait_idle("dbl", 1'b0);
        repeat (5) @(negedge clk);
        #2;
        check("dbl_xfers", 32'(xd.size()), 32'd3);
        check("dbl_done", 32'(done_cnt), 32'd1);
        check("dbl_reads", 32'(rd_addrs.size()), 32'd4);
        check("dbl_busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_reader.md
BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 Parameter DATA_W, default 32: BRAM word width and stream data width.
REQ-002 Parameter DEPTH, default 1024: maximum number of sample words in one frame.
REQ-003 Parameter FLAG_ADDR, default 0: byte address of the frame-flag word.
REQ-004 Parameter BASE_ADDR, default 4: byte address of sample 0; sample k is at BASE_ADDR + 4*k.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock; all logic is synchronous to it.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle request to poll the flag word and drain one frame.
REQ-009 enable  out  1  BRAM port enable.
REQ-010 we  out  1  BRAM write enable; asserted only for the flag-clear write.
REQ-011 addr  out  32  BRAM byte address.
REQ-012 din  out  DATA_W  BRAM write data.
REQ-013 dout  in  DATA_W  BRAM read data; valid on the cycle after enable=1 and we=0.
REQ-014 m_data  out  DATA_W  output sample.
REQ-015 m_valid  out  1  m_data is valid.
REQ-016 m_ready  in  1  consumer accepts m_data.
REQ-017 m_last  out  1  marks the final sample of the frame; qualified by m_valid.
REQ-018 busy  out  1  high from start acceptance until the frame is completed.
REQ-019 done  out  1  one-cycle pulse when the flag-clear write is issued.
REQ-020 ovf  out  1  one-cycle pulse when the flag count was clamped to DEPTH.

Function
REQ-021 The state machine SHALL use the states IDLE, POLL, CHECK, STREAM, DRAIN, CLEAR, with transitions as follows.
- IDLE to POLL: on start=1.
- POLL: one read of FLAG_ADDR (enable=1, we=0), then CHECK.
- CHECK: samples dout as N.
  - If N=0: return to IDLE and deassert busy; no done pulse.
  - If N>0: load the remaining count with min(N, DEPTH) and enter STREAM.
- STREAM: issues sequential reads from BASE_ADDR until min(N, DEPTH) reads are issued, then DRAIN.
- DRAIN: waits until all in-flight and buffered words are accepted, then CLEAR.
- CLEAR: one write (enable=1, we=1, addr=FLAG_ADDR, din=0), pulses done, then IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 The block SHALL use a 2-entry output FIFO.
- A read is issued in a cycle only if FIFO occupancy, plus reads in flight, minus the pop this cycle, is less than 2.
- No BRAM word shall ever be dropped.
REQ-024 With m_ready held high, the block SHALL sustain 1 word per cycle in STREAM; the first m_valid occurs 2 cycles after the first read issue.
REQ-025 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-026 A transfer SHALL occur only when m_valid=1 and m_ready=1.
REQ-027 m_last SHALL be 1 only on the word with index min(N, DEPTH)-1.
REQ-028 If N > DEPTH, the block SHALL pulse ovf once during CHECK and stream exactly DEPTH words.
REQ-029 enable SHALL be 0 in every cycle without a BRAM access; addr SHALL hold its last value.
REQ-030 The sample address counter SHALL be 32-bit, increment by 4, and restart at BASE_ADDR on each frame.
REQ-031 Outside CLEAR, we SHALL remain 0.

Reset
REQ-032 When rst_n=0, the block SHALL force the following, regardless of state:
- state = IDLE; enable=0, we=0, addr=FLAG_ADDR, din=0;
- m_valid=0, m_last=0, m_data=0;
- busy=0, done=0, ovf=0;
- FIFO and in-flight counters cleared.
REQ-033 A reset mid-frame SHALL abandon the frame without a flag-clear write; the flag word stays nonzero, and the next start re-reads the frame from sample 0.
REQ-034 Outputs SHALL change only on rising clk edges after rst_n deasserts.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Flag=3, samples 0xA,0xB,0xC, m_ready=1 → m_data A,B,C on consecutive cycles; m_last on C; one write of 0 to addr 0; done pulses once.
- Flag=0, start → single read of addr 0; return to IDLE; no m_valid; no done; no write.
- Flag=4, m_ready toggling 1,0,0,1,... → exactly 4 transfers in order; m_data stable during stalls; no duplicates or drops.
- Flag=DEPTH+5 → ovf pulses once; DEPTH words streamed; last word read at BASE_ADDR+4*(DEPTH-1).
- rst_n low after 2 of 5 words → all outputs at reset values; no write to FLAG_ADDR; next start streams all 5 words from sample 0.
- start pulsed again during STREAM → ignored; a single frame is produced with a single done.
